rv32im_single_cycle_core: RTL and testbench

- Single-cycle RV32IM processor: one instruction fetched, decoded, executed and written back per clock.
- Contains PC, 32x32 register file, word-addressed instruction memory, word-addressed data memory, ALU and combinational M-extension unit.
- Top-level design unit. Program, data and register contents are preloaded hierarchically by the bench.

---
 rtl/rv32im_single_cycle_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rv32im_single_cycle_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_single_cycle_core.sv
// ============================================================================
// Module      : rv32im_single_cycle_core
// Description : Single-cycle RV32IM core with a program counter, a register
//               file, instruction/data memories, an ALU and a
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) Registers[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : Registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : Registers[raddr2_i];
endmodule

module rv32_imem #(
  parameter int DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] data_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] immem_block [0:DEPTH-1];
  logic [29:0] word;
  logic        in_range;
  logic        unused_ok;

  assign word      = addr_i[31:2];
  assign in_range  = (word < 30'(DEPTH));
  assign unused_ok = &{1'b0, addr_i[1:0]};

  // Write port reserved for in-system program loading; tied off at the top.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range) immem_block[word[AW-1:0]] <= wdata_i;
  end

  assign data_o = in_range ? immem_block[word[AW-1:0]] : 32'h0;
endmodule

module rv32_dmem #(
  parameter int DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] data_mem_block [0:DEPTH-1];
  logic [29:0] word;
  logic        in_range;
  logic        unused_ok;

  assign word      = addr_i[31:2];
  assign in_range  = (word < 30'(DEPTH));
  assign unused_ok = &{1'b0, addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (we_i && in_range) data_mem_block[word[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = in_range ? data_mem_block[word[AW-1:0]] : 32'h0;
endmodule

module rv32im_single_cycle_core #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic reset
);
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  logic [31:0] pc, pc_d, pc_plus4, instruction;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        reg_write, branch, jump, branch_taken, mem_write;
  logic [31:0] wb_data, rs1_data, rs2_data, alu_b, alu_result, mdu_result;
  logic [31:0] dmem_addr, dmem_rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'h0;
    else       pc <= pc_d;
  end

  rv32_imem #(.DEPTH(IMEM_DEPTH)) Intruction_Memory (
    .clk_i(clk), .we_i(1'b0), .addr_i(pc), .wdata_i(32'h0), .data_o(instruction)
  );

  assign opcode   = instruction[6:0];
  assign rd       = instruction[11:7];
  assign funct3   = instruction[14:12];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign funct7   = instruction[31:25];
  assign pc_plus4 = pc + 32'd4;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'h0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  rv32_regfile Register_File (
    .clk_i(clk), .we_i(reg_write), .waddr_i(rd), .wdata_i(wb_data),
    .raddr1_i(rs1), .raddr2_i(rs2), .rdata1_o(rs1_data), .rdata2_o(rs2_data)
  );

  // ALU shared by register and immediate forms; only R-type can subtract.
  assign alu_b = (opcode == c_OP_REG) ? rs2_data : imm_i;

  always_comb begin
    alu_result = 32'h0;
    case (funct3)
      3'b000: alu_result = ((opcode == c_OP_REG) && funct7[5]) ? rs1_data - alu_b
                                                               : rs1_data + alu_b;
      3'b001: alu_result = rs1_data << alu_b[4:0];
      3'b010: alu_result = {31'h0, $signed(rs1_data) < $signed(alu_b)};
      3'b011: alu_result = {31'h0, rs1_data < alu_b};
      3'b100: alu_result = rs1_data ^ alu_b;
      3'b101: alu_result = instruction[30] ? 32'($signed(rs1_data) >>> alu_b[4:0])
                                           : rs1_data >> alu_b[4:0];
      3'b110: alu_result = rs1_data | alu_b;
      default: alu_result = rs1_data & alu_b;
    endcase
  end

  // One 33x33 signed multiplier covers all four products via operand extension.
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] product;
  logic               div_zero, div_ovf;
  logic               unused_ok;

  assign mul_a     = {(funct3[1:0] != 2'b11) & rs1_data[31], rs1_data};
  assign mul_b     = {~funct3[1] & rs2_data[31], rs2_data};
  assign product   = mul_a * mul_b;
  assign div_zero  = (rs2_data == 32'h0);
  assign div_ovf   = (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign unused_ok = &{1'b0, product[65:64]};

  always_comb begin
    mdu_result = 32'h0;
    case (funct3)
      3'b000: mdu_result = product[31:0];
      3'b001, 3'b010, 3'b011: mdu_result = product[63:32];
      3'b100: begin
        if (div_zero)     mdu_result = 32'hFFFF_FFFF;
        else if (div_ovf) mdu_result = 32'h8000_0000;
        else              mdu_result = 32'($signed(rs1_data) / $signed(rs2_data));
      end
      3'b101: mdu_result = div_zero ? 32'hFFFF_FFFF : rs1_data / rs2_data;
      3'b110: begin
        if (div_zero)     mdu_result = rs1_data;
        else if (div_ovf) mdu_result = 32'h0;
        else              mdu_result = 32'($signed(rs1_data) % $signed(rs2_data));
      end
      default: mdu_result = div_zero ? rs1_data : rs1_data % rs2_data;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rs1_data == rs2_data);
      3'b001: branch_taken = (rs1_data != rs2_data);
      3'b100: branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: branch_taken = (rs1_data <  rs2_data);
      3'b111: branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  assign dmem_addr = rs1_data + ((opcode == c_OP_STORE) ? imm_s : imm_i);
  assign mem_write = (opcode == c_OP_STORE);

  rv32_dmem #(.DEPTH(DMEM_DEPTH)) Data_Memory (
    .clk_i(clk), .we_i(mem_write), .addr_i(dmem_addr), .wdata_i(rs2_data),
    .rdata_o(dmem_rdata)
  );

  always_comb begin
    reg_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    wb_data   = alu_result;
    pc_d      = pc_plus4;
    case (opcode)
      c_OP_REG: begin
        if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) begin
          reg_write = 1'b1;
        end else if (funct7 == 7'b0000001) begin
          reg_write = 1'b1;
          wb_data   = mdu_result;
        end
      end
      c_OP_IMM:   reg_write = 1'b1;
      c_OP_LUI: begin
        reg_write = 1'b1;
        wb_data   = imm_u;
      end
      c_OP_AUIPC: begin
        reg_write = 1'b1;
        wb_data   = pc + imm_u;
      end
      c_OP_LOAD: begin
        reg_write = 1'b1;
        wb_data   = dmem_rdata;
      end
      c_OP_BRANCH: begin
        branch = 1'b1;
        if (branch_taken) pc_d = pc + imm_b;
      end
      c_OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        wb_data   = pc_plus4;
        pc_d      = pc + imm_j;
      end
      c_OP_JALR: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        wb_data   = pc_plus4;
        pc_d      = (rs1_data + imm_i) & ~32'h1;
      end
      default: ;
    endcase
  end
endmodule

`default_nettype wire

// File: tb/tb_rv32im_single_cycle_core.sv
// ============================================================================
// Module      : tb_rv32im_single_cycle_core
// Description : Directed program bench for the single-cycle RV32IM core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32im_single_cycle_core;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32im_single_cycle_core #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset)
  );

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_op(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_op(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_op(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] u_op(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] j_op(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic prog(input int w, input logic [31:0] ins);
    dut.Intruction_Memory.immem_block[w] = ins;
  endtask

  function automatic logic [31:0] xr(input int i);
    return dut.Register_File.Registers[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_pc(input logic [31:0] target, input string tag);
    int n = 0;
    while ((dut.pc !== target) && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, dut.pc, target);
  endtask

  localparam logic [6:0] M  = 7'b0000001;
  localparam logic [6:0] AL = 7'b0000000;
  localparam logic [6:0] AH = 7'b0100000;
  localparam logic [6:0] OI = 7'b0010011;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 32; i++)   dut.Register_File.Registers[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dut.Intruction_Memory.immem_block[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dut.Data_Memory.data_mem_block[i] = 32'h0;
    dut.Register_File.Registers[1] = 32'd5;
    dut.Register_File.Registers[2] = 32'd3;
    dut.Register_File.Registers[3] = 32'd20;
    dut.Register_File.Registers[4] = 32'd7;
    dut.Register_File.Registers[5] = 32'd100;
    dut.Register_File.Registers[6] = 32'hFFFF_FFFF;
    dut.Data_Memory.data_mem_block[0] = 32'hDEAD_BEEF;

    prog(1,  r_op(M, 3'd0, 5'd7,  5'd1, 5'd2));     // MUL
    prog(2,  r_op(M, 3'd1, 5'd8,  5'd1, 5'd2));     // MULH
    prog(3,  r_op(M, 3'd3, 5'd9,  5'd1, 5'd2));     // MULHU
    prog(4,  r_op(M, 3'd2, 5'd11, 5'd1, 5'd2));     // MULHSU
    prog(5,  r_op(M, 3'd4, 5'd12, 5'd3, 5'd2));     // DIV
    prog(6,  r_op(M, 3'd5, 5'd13, 5'd5, 5'd4));     // DIVU
    prog(7,  r_op(M, 3'd6, 5'd14, 5'd3, 5'd2));     // REM
    prog(8,  r_op(M, 3'd7, 5'd15, 5'd5, 5'd4));     // REMU
    prog(9,  r_op(AL, 3'd0, 5'd18, 5'd7, 5'd12));   // ADD
    prog(10, r_op(AH, 3'd0, 5'd19, 5'd18, 5'd1));   // SUB
    prog(11, r_op(AL, 3'd2, 5'd20, 5'd1, 5'd2));    // SLT
    prog(12, r_op(AL, 3'd3, 5'd21, 5'd1, 5'd2));    // SLTU
    prog(13, r_op(AL, 3'd7, 5'd24, 5'd18, 5'd7));   // AND
    prog(14, r_op(AL, 3'd6, 5'd25, 5'd18, 5'd7));   // OR
    prog(15, r_op(AL, 3'd4, 5'd26, 5'd18, 5'd7));   // XOR
    prog(16, r_op(AL, 3'd1, 5'd27, 5'd1, 5'd2));    // SLL
    prog(17, r_op(AL, 3'd5, 5'd28, 5'd5, 5'd2));    // SRL
    prog(18, r_op(AH, 3'd5, 5'd29, 5'd6, 5'd2));    // SRA
    prog(19, i_op(OI, 3'd0, 5'd30, 5'd18, 12'd10)); // ADDI
    prog(20, i_op(OI, 3'd2, 5'd31, 5'd1, 12'd10));  // SLTI
    prog(21, i_op(OI, 3'd7, 5'd16, 5'd18, 12'd7));  // ANDI
    prog(22, r_op(AL, 3'd0, 5'd10, 5'd7, 5'd0));    // x10 = 15
    prog(23, s_op(5'd10, 5'd0, 12'd8));             // SW x10,8(x0)
    prog(24, i_op(7'h03, 3'd2, 5'd11, 5'd0, 12'd8));
    prog(25, i_op(7'h03, 3'd2, 5'd12, 5'd0, 12'd0));
    prog(26, b_op(3'd0, 5'd1, 5'd1, 13'd8));        // BEQ
    prog(27, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(28, i_op(OI, 3'd0, 5'd13, 5'd0, 12'd77));
    prog(29, b_op(3'd1, 5'd1, 5'd2, 13'd8));        // BNE
    prog(30, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(31, i_op(OI, 3'd0, 5'd14, 5'd0, 12'd66));
    prog(32, b_op(3'd4, 5'd1, 5'd3, 13'd8));        // BLT
    prog(33, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(34, i_op(OI, 3'd0, 5'd15, 5'd0, 12'd44));
    prog(35, b_op(3'd5, 5'd3, 5'd1, 13'd8));        // BGE
    prog(36, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(37, i_op(OI, 3'd0, 5'd16, 5'd0, 12'd22));
    prog(38, r_op(M, 3'd4, 5'd24, 5'd3, 5'd0));     // DIV by zero
    prog(39, r_op(M, 3'd6, 5'd25, 5'd3, 5'd0));     // REM by zero
    prog(40, i_op(OI, 3'd0, 5'd0, 5'd0, 12'd5));    // write to x0
    prog(41, u_op(7'h37, 5'd26, 20'h80000));        // LUI
    prog(42, r_op(M, 3'd4, 5'd27, 5'd26, 5'd6));    // DIV overflow
    prog(43, j_op(5'd17, 21'd12));                  // JAL
    prog(44, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(45, i_op(OI, 3'd0, 5'd20, 5'd0, 12'd99));
    prog(46, r_op(M, 3'd6, 5'd28, 5'd26, 5'd6));    // REM overflow
    prog(47, u_op(7'h17, 5'd29, 20'h00001));        // AUIPC
    prog(48, i_op(7'h67, 3'd0, 5'd22, 5'd0, 12'd200)); // JALR
    prog(49, i_op(OI, 3'd0, 5'd23, 5'd0, 12'd999));
    prog(50, i_op(OI, 3'd0, 5'd23, 5'd0, 12'd888));

    #1;
    chk("reset_pc", dut.pc, 32'h0);
    chk("reset_instr", dut.instruction, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    wait_pc(32'd88, "pc_arith_done");
    chk("mul", xr(7), 32'd15);
    chk("mulh", xr(8), 32'd0);
    chk("mulhu", xr(9), 32'd0);
    chk("mulhsu", xr(11), 32'd0);
    chk("div", xr(12), 32'd6);
    chk("divu", xr(13), 32'd14);
    chk("rem", xr(14), 32'd2);
    chk("remu", xr(15), 32'd2);
    chk("add", xr(18), 32'd21);
    chk("sub", xr(19), 32'd16);
    chk("slt", xr(20), 32'd0);
    chk("sltu", xr(21), 32'd0);
    chk("and", xr(24), 32'd5);
    chk("or", xr(25), 32'd31);
    chk("xor", xr(26), 32'd26);
    chk("sll", xr(27), 32'd40);
    chk("srl", xr(28), 32'd12);
    chk("sra", xr(29), 32'hFFFF_FFFF);
    chk("addi", xr(30), 32'd31);
    chk("slti", xr(31), 32'd1);
    chk("andi", xr(16), 32'd5);

    wait_pc(32'd104, "pc_at_beq");
    chk("x10", xr(10), 32'd15);
    chk("sw_mem", dut.Data_Memory.data_mem_block[2], 32'd15);
    chk("lw_stored", xr(11), 32'd15);
    chk("lw_preload", xr(12), 32'hDEAD_BEEF);
    chk("beq_opcode", {25'h0, dut.opcode}, 32'h63);
    chk("beq_branch", {31'h0, dut.branch}, 32'd1);
    chk("beq_taken", {31'h0, dut.branch_taken}, 32'd1);

    wait_pc(32'd172, "pc_at_jal");
    chk("beq_target", xr(13), 32'd77);
    chk("bne_target", xr(14), 32'd66);
    chk("blt_target", xr(15), 32'd44);
    chk("bge_target", xr(16), 32'd22);
    chk("skipped_addi", xr(20), 32'd0);
    chk("div_by_zero", xr(24), 32'hFFFF_FFFF);
    chk("rem_by_zero", xr(25), 32'd20);
    chk("x0_write", xr(0), 32'd0);
    chk("lui", xr(26), 32'h8000_0000);
    chk("div_ovf", xr(27), 32'h8000_0000);
    chk("jal_jump", {31'h0, dut.jump}, 32'd1);
    chk("jal_rd", {27'h0, dut.rd}, 32'd17);
    chk("jal_wb", dut.wb_data, 32'd176);
    chk("jal_regwrite", {31'h0, dut.reg_write}, 32'd1);

    @(posedge clk);
    #1;
    chk("jal_target", dut.pc, 32'hB8);

    wait_pc(32'hC0, "pc_at_jalr");
    chk("jal_link", xr(17), 32'd176);
    chk("jal_skip", xr(20), 32'd0);
    chk("rem_ovf", xr(28), 32'd0);
    chk("auipc", xr(29), 32'h0000_10BC);
    chk("jalr_jump", {31'h0, dut.jump}, 32'd1);

    wait_pc(32'd204, "pc_after_jalr");
    chk("jalr_link", xr(22), 32'd196);
    chk("jalr_target", xr(23), 32'd888);

    repeat (3) @(posedge clk);
    #1;
    chk("nop_pc", dut.pc, 32'd216);
    chk("nop_instr", dut.instruction, 32'h0);
    chk("nop_regwrite", {31'h0, dut.reg_write}, 32'd0);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pc", dut.pc, 32'h0);
    chk("reset_keeps_regs", xr(23), 32'd888);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_pc", dut.pc, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
